// File: rtl/mem_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_control_if
//  Brief    : CPU/bus-side signal bundle for the memory-request controller.
//             The master side drives requests and bus read data; the slave
//             side (mem_control) returns state, address and routed data.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_control_if;
  logic [31:0] address_in;
  logic [31:0] data_in_CPU;
  logic [31:0] data_in_BUS;
  logic        data_en;
  logic        instr_en;
  logic        bus_full;
  logic        memWrite;
  logic        memRead;
  logic [2:0]  state;
  logic [31:0] address_out;
  logic [31:0] data_out_CPU;
  logic [31:0] data_out_BUS;
  logic [31:0] data_out_INSTR;

  modport master (
    output address_in, data_in_CPU, data_in_BUS,
    output data_en, instr_en, bus_full, memWrite, memRead,
    input  state, address_out, data_out_CPU, data_out_BUS, data_out_INSTR
  );

  modport slave (
    input  address_in, data_in_CPU, data_in_BUS,
    input  data_en, instr_en, bus_full, memWrite, memRead,
    output state, address_out, data_out_CPU, data_out_BUS, data_out_INSTR
  );
endinterface
`default_nettype wire

// File: rtl/mem_control.sv
`default_nettype none
// ============================================================================
//  Module   : mem_control
//  Brief    : Memory-request controller between the RV32I core and the shared
//             memory bus. Turns data reads/writes and instruction fetches into
//             single-cycle bus transfers, stalling while the bus is full.
//  Revision : 1.0  initial release
// ============================================================================
module mem_control #(
  parameter logic [31:0] FILL_VALUE = 32'hABCD
) (
  input logic          clk,
  input logic          rst,
  mem_control_if.slave bus
);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_READ_REQ  = 3'd2,
    S_WRITE_REQ = 3'd3,
    S_READ      = 3'd4,
    S_WRITE     = 3'd5,
    S_WAIT      = 3'd6
  } state_t;

  // Kind of transfer captured when a request leaves IDLE; steers the Wait exit
  // and selects the destination of read data.
  typedef enum logic [1:0] {
    OP_READ_DATA = 2'd0,
    OP_WRITE     = 2'd1,
    OP_FETCH     = 2'd2
  } op_t;

  state_t r_state;
  state_t w_next_state;
  op_t    r_pending;
  op_t    w_next_pending;
  logic   r_turnaround;
  logic   w_next_turnaround;
  logic   w_any_en;

  assign w_any_en = bus.data_en | bus.instr_en;

  // State, pending-op and turnaround registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_pending    <= OP_READ_DATA;
      r_turnaround <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_pending    <= w_next_pending;
      r_turnaround <= w_next_turnaround;
    end
  end

  // Next-state decode, request priority and turnaround tracking.
  always_comb begin
    w_next_state      = r_state;
    w_next_pending    = r_pending;
    // Set only on the way out of a transfer, so the following IDLE cycle
    // ignores requests and decode resumes the cycle after.
    w_next_turnaround = 1'b0;
    case (r_state)
      S_INIT: w_next_state = S_IDLE;
      S_IDLE: begin
        if (!r_turnaround) begin
          if (w_any_en && bus.memRead) begin
            w_next_state   = S_READ_REQ;
            w_next_pending = OP_READ_DATA;
          end else if (w_any_en && bus.memWrite) begin
            w_next_state   = S_WRITE_REQ;
            w_next_pending = OP_WRITE;
          end else if (bus.instr_en) begin
            w_next_state   = S_READ_REQ;
            w_next_pending = OP_FETCH;
          end
        end
      end
      S_READ_REQ:  w_next_state = bus.bus_full ? S_WAIT : S_READ;
      S_WRITE_REQ: w_next_state = bus.bus_full ? S_WAIT : S_WRITE;
      S_WAIT: begin
        if (!bus.bus_full) begin
          w_next_state = (r_pending == OP_WRITE) ? S_WRITE : S_READ;
        end
      end
      S_READ, S_WRITE: begin
        w_next_state      = S_IDLE;
        w_next_turnaround = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Moore-state output routing; address and data pass straight through.
  always_comb begin
    bus.address_out    = FILL_VALUE;
    bus.data_out_CPU   = FILL_VALUE;
    bus.data_out_BUS   = FILL_VALUE;
    bus.data_out_INSTR = FILL_VALUE;
    case (r_state)
      S_READ: begin
        if (r_pending == OP_READ_DATA) begin
          bus.address_out    = bus.address_in;
          bus.data_out_CPU   = bus.data_in_BUS;
          bus.data_out_BUS   = 32'd0;
          bus.data_out_INSTR = 32'd0;
        end else if (r_pending == OP_FETCH) begin
          bus.address_out    = bus.address_in;
          bus.data_out_CPU   = 32'd0;
          bus.data_out_BUS   = 32'd0;
          bus.data_out_INSTR = bus.data_in_BUS;
        end
      end
      S_WRITE: begin
        bus.address_out    = bus.address_in;
        bus.data_out_CPU   = 32'd0;
        bus.data_out_BUS   = bus.data_in_CPU;
        bus.data_out_INSTR = 32'd0;
      end
      default: ;
    endcase
  end

  assign bus.state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_control
//  Brief    : Self-checking bench for mem_control. Each request is expanded
//             into its expected per-cycle state/output sequence from the
//             controller's transaction rules and compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_control;

  localparam logic [31:0] FILL = 32'hABCD;

  // State encodings as seen on the state port.
  localparam int ST_INIT = 0;
  localparam int ST_IDLE = 1;
  localparam int ST_RREQ = 2;
  localparam int ST_WREQ = 3;
  localparam int ST_READ = 4;
  localparam int ST_WRIT = 5;
  localparam int ST_WAIT = 6;

  // Transfer kinds derived from the request inputs.
  localparam int K_NONE  = 0;
  localparam int K_RDATA = 1;
  localparam int K_WRITE = 2;
  localparam int K_FETCH = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_control_if bus_if ();

  mem_control #(.FILL_VALUE(FILL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int exp);
    check({tag, ".state"}, {29'd0, bus_if.state}, exp[31:0]);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] a, input logic [31:0] c,
                            input logic [31:0] b, input logic [31:0] i);
    check({tag, ".addr"},  bus_if.address_out,    a);
    check({tag, ".cpu"},   bus_if.data_out_CPU,   c);
    check({tag, ".bus"},   bus_if.data_out_BUS,   b);
    check({tag, ".instr"}, bus_if.data_out_INSTR, i);
  endtask

  task automatic check_fill(input string tag);
    check_outs(tag, FILL, FILL, FILL, FILL);
  endtask

  task automatic drive_req(input bit de, input bit ie, input bit mr, input bit mw);
    bus_if.data_en  = de;
    bus_if.instr_en = ie;
    bus_if.memRead  = mr;
    bus_if.memWrite = mw;
  endtask

  task automatic scramble();
    drive_req(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    bus_if.address_in  = $urandom;
    bus_if.data_in_CPU = $urandom;
    bus_if.data_in_BUS = $urandom;
  endtask

  // One request issued from a decoding IDLE cycle, with k cycles of bus_full.
  // Leaves the DUT in a decoding IDLE cycle on return.
  task automatic do_txn(input bit de, input bit ie, input bit mr, input bit mw, input int k,
                        input logic [31:0] a, input logic [31:0] dc, input logic [31:0] db);
    int kind;
    if ((de || ie) && mr)      kind = K_RDATA;
    else if ((de || ie) && mw) kind = K_WRITE;
    else if (ie)               kind = K_FETCH;
    else                       kind = K_NONE;

    drive_req(de, ie, mr, mw);
    bus_if.bus_full = 1'($urandom);
    #1;
    check_state("decode", ST_IDLE);
    check_fill("decode");
    next_cycle();

    if (kind == K_NONE) begin
      check_state("no_request", ST_IDLE);
      return;
    end

    scramble();
    bus_if.bus_full = (k > 0);
    #1;
    check_state("request", (kind == K_WRITE) ? ST_WREQ : ST_RREQ);
    check_fill("request");

    for (int j = 1; j <= k; j++) begin
      next_cycle();
      scramble();
      bus_if.bus_full = (j < k);
      #1;
      check_state("wait", ST_WAIT);
      check_fill("wait");
    end

    next_cycle();
    scramble();
    bus_if.bus_full    = 1'($urandom);
    bus_if.address_in  = a;
    bus_if.data_in_CPU = dc;
    bus_if.data_in_BUS = db;
    #1;
    case (kind)
      K_RDATA: begin
        check_state("xfer_rd", ST_READ);
        check_outs("xfer_rd", a, db, 32'd0, 32'd0);
      end
      K_FETCH: begin
        check_state("xfer_fetch", ST_READ);
        check_outs("xfer_fetch", a, 32'd0, 32'd0, db);
      end
      default: begin
        check_state("xfer_wr", ST_WRIT);
        check_outs("xfer_wr", a, 32'd0, dc, 32'd0);
      end
    endcase

    // Turnaround: a live request here must be ignored.
    next_cycle();
    drive_req(1'b1, 1'($urandom), 1'b1, 1'($urandom));
    bus_if.bus_full = 1'b0;
    #1;
    check_state("turnaround", ST_IDLE);
    check_fill("turnaround");
    next_cycle();
    check_state("after_turn", ST_IDLE);
  endtask

  initial begin
    rst = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0);
    bus_if.bus_full    = 1'b0;
    bus_if.address_in  = 32'd0;
    bus_if.data_in_CPU = 32'd0;
    bus_if.data_in_BUS = 32'd0;
    repeat (2) next_cycle();
    check_state("reset", ST_INIT);
    check_fill("reset");

    // Release with a read already requested; INIT does not decode.
    drive_req(1'b1, 1'b0, 1'b1, 1'b0);
    bus_if.address_in  = 32'd1;
    bus_if.data_in_BUS = 32'd1;
    rst = 1'b0;
    next_cycle();
    check_state("release", ST_IDLE);

    do_txn(1, 0, 1, 0, 0, 32'd1, 32'd0, 32'd1);            // data read
    do_txn(1, 0, 0, 1, 0, 32'd1, 32'd1, 32'd0);            // data write
    do_txn(1, 0, 0, 1, 3, 32'h10, 32'h55, 32'h66);         // write stalled
    do_txn(1, 0, 1, 1, 0, 32'h20, 32'h77, 32'h88);         // read beats write
    do_txn(1, 1, 1, 1, 0, 32'h24, 32'h99, 32'hAA);
    repeat (3) do_txn(0, 0, 1, 1, 0, 32'd0, 32'd0, 32'd0); // no enable
    do_txn(0, 1, 1, 0, 0, 32'h30, 32'h11, 32'h1234);       // instr_en + read
    do_txn(0, 1, 0, 0, 2, 32'h34, 32'h22, 32'h5678);       // fetch

    for (int n = 0; n < 60; n++) begin
      int k;
      k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      do_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), k,
             $urandom, $urandom, $urandom);
    end

    // Reset asserted while stalled in Wait.
    drive_req(1'b1, 1'b0, 1'b0, 1'b1);
    bus_if.bus_full = 1'b1;
    next_cycle();
    check_state("rst_wait.req", ST_WREQ);
    next_cycle();
    check_state("rst_wait.wait", ST_WAIT);
    rst = 1'b1;
    next_cycle();
    check_state("rst_wait.init", ST_INIT);
    check_fill("rst_wait.init");
    rst = 1'b0;
    bus_if.bus_full = 1'b0;
    next_cycle();
    check_state("rst_wait.idle", ST_IDLE);
    do_txn(1, 0, 1, 0, 0, 32'h40, 32'h0, 32'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
